// File: rtl/mips_cpu_lsu_pkg.sv
// mips_cpu_lsu_pkg: op and state encodings shared by the load/store unit.
package mips_cpu_lsu_pkg;
  typedef enum logic [3:0] {LB = 4'd0, LBU, LH, LHU, LW, LWL, LWR, SB, SH, SW} lsu_op_t;
  typedef enum logic [2:0] {IDLE, LOAD, WRITE, RMW_RD, RMW_WR, ERR} state_t;
  function automatic logic is_load(input logic [3:0] op);
    return op <= LWR;
  endfunction
  function automatic logic is_store(input logic [3:0] op);
    return op >= SB && op <= SW;
  endfunction
endpackage

// File: rtl/mips_cpu_lsu_align.sv
// mips_cpu_lsu_align: load extraction, sub-word store merge and alignment check.
module mips_cpu_lsu_align
  import mips_cpu_lsu_pkg::*;
#(
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic [3:0]  i_op,
  input  logic [1:0]  i_k,
  input  logic [31:0] i_mem,
  input  logic [31:0] i_rt_old,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_store,
  output logic        o_misaligned
);
  logic [4:0]  w_sh;
  logic [4:0]  w_shl;
  logic [4:0]  w_hs;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  assign w_sh   = {i_k, 3'b000};
  assign w_shl  = {~i_k, 3'b000};
  assign w_hs   = {i_k[1], 4'b0000};
  assign w_byte = 8'(i_mem >> w_sh);
  assign w_half = i_k[1] ? i_mem[31:16] : i_mem[15:0];
  always_comb begin
    case (i_op)
      LB:      o_load = {{24{w_byte[7]}}, w_byte};
      LBU:     o_load = {24'd0, w_byte};
      LH:      o_load = {{16{w_half[15]}}, w_half};
      LHU:     o_load = {16'd0, w_half};
      LWL:     o_load = (i_mem << w_shl) | (i_rt_old & ((32'd1 << w_shl) - 32'd1));
      LWR:     o_load = (i_mem >> w_sh) | (i_rt_old & ~(32'hFFFF_FFFF >> w_sh));
      default: o_load = i_mem;
    endcase
  end
  assign o_store = (i_op == SB) ? (i_mem & ~(32'hFF << w_sh)) | ({24'd0, i_wdata[7:0]} << w_sh)
                 : (i_op == SH) ? (i_mem & ~(32'hFFFF << w_hs)) | ({16'd0, i_wdata[15:0]} << w_hs)
                 : i_wdata;
  // Undefined opcodes share the error path with misaligned accesses.
  assign o_misaligned = (i_op > SW)
    || (CHECK_ALIGN && (((i_op == LH || i_op == LHU || i_op == SH) && i_k[0])
                     || ((i_op == LW || i_op == SW) && i_k != 2'b00)));
endmodule

// File: rtl/mips_cpu_lsu.sv
// mips_cpu_lsu: FSM turning core load/store requests into word-aligned bus cycles.
module mips_cpu_lsu
  import mips_cpu_lsu_pkg::*;
#(
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [3:0]  i_req_op,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [31:0] i_req_rt_old,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_err,
  output logic [31:0] o_data_address,
  output logic        o_data_read,
  output logic        o_data_write,
  output logic [31:0] o_data_writedata,
  input  logic [31:0] i_data_readdata
);
  state_t      r_state;
  logic [3:0]  r_op;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rt_old;
  logic [31:0] r_buf;
  logic [31:0] w_load;
  logic [31:0] w_store;
  logic        w_mis;
  logic        w_idle;
  assign w_idle = r_state == IDLE;
  // Alignment is judged on the live request while idle, on the latched one otherwise.
  mips_cpu_lsu_align #(.CHECK_ALIGN(CHECK_ALIGN)) u_align (
    .i_op        (w_idle ? i_req_op : r_op),
    .i_k         (w_idle ? i_req_addr[1:0] : r_addr[1:0]),
    .i_mem       (i_data_readdata),
    .i_rt_old    (r_rt_old),
    .i_wdata     (r_wdata),
    .o_load      (w_load),
    .o_store     (w_store),
    .o_misaligned(w_mis)
  );
  assign o_req_ready      = w_idle;
  assign o_data_address   = {r_addr[31:2], 2'b00};
  assign o_data_read      = r_state == LOAD || r_state == RMW_RD;
  assign o_data_write     = r_state == WRITE || r_state == RMW_WR;
  assign o_data_writedata = r_state == RMW_WR ? r_buf : r_state == WRITE ? r_wdata : 32'd0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_op         <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rt_old     <= '0;
      r_buf        <= '0;
      o_resp_valid <= 1'b0;
      o_resp_err   <= 1'b0;
      o_resp_rdata <= '0;
    end else begin
      o_resp_valid <= 1'b0;
      o_resp_err   <= 1'b0;
      case (r_state)
        IDLE: if (i_req_valid) begin
          r_op     <= i_req_op;
          r_addr   <= i_req_addr;
          r_wdata  <= i_req_wdata;
          r_rt_old <= i_req_rt_old;
          r_state  <= w_mis ? ERR : is_load(i_req_op) ? LOAD : i_req_op == SW ? WRITE : RMW_RD;
        end
        LOAD: begin
          o_resp_rdata <= w_load;
          o_resp_valid <= 1'b1;
          r_state      <= IDLE;
        end
        RMW_RD: begin
          r_buf   <= w_store;
          r_state <= RMW_WR;
        end
        ERR: begin
          o_resp_valid <= 1'b1;
          o_resp_err   <= 1'b1;
          r_state      <= IDLE;
        end
        default: begin
          o_resp_valid <= 1'b1;
          r_state      <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mips_cpu_lsu.sv
// tb_mips_cpu_lsu: directed scoreboard bench for mips_cpu_lsu against a word memory model.
module tb_mips_cpu_lsu;
  import mips_cpu_lsu_pkg::*;
  typedef struct {
    logic [31:0] rdata;
    logic        chk_rd;
    logic        err;
    int          rd;
    int          wr;
    int          lat;
    int          t0;
    logic [31:0] addr;
  } sb_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [31:0] req_rt_old = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] data_address;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;
  logic [31:0] mem [0:2047];
  logic        pl_en = 1'b0;
  logic [10:0] pl_idx = '0;
  logic [31:0] pl_val = '0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          rd_n = 0;
  int          wr_n = 0;
  sb_t         q[$];
  mips_cpu_lsu #(.CHECK_ALIGN(1'b1)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_req_valid     (req_valid),
    .o_req_ready     (req_ready),
    .i_req_op        (req_op),
    .i_req_addr      (req_addr),
    .i_req_wdata     (req_wdata),
    .i_req_rt_old    (req_rt_old),
    .o_resp_valid    (resp_valid),
    .o_resp_rdata    (resp_rdata),
    .o_resp_err      (resp_err),
    .o_data_address  (data_address),
    .o_data_read     (data_read),
    .o_data_write    (data_write),
    .o_data_writedata(data_writedata),
    .i_data_readdata (data_readdata)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign data_readdata = mem[data_address[12:2]];
  always @(posedge clk) begin
    if (data_write) mem[data_address[12:2]] <= data_writedata;
    else if (pl_en) mem[pl_idx] <= pl_val;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n) begin
      if (data_read || data_write) begin
        chk("bus_exclusive", 32'(data_read & data_write), 32'd0);
        if (q.size() != 0) chk("bus_addr", data_address, {q[0].addr[31:2], 2'b00});
        rd_n += int'(data_read);
        wr_n += int'(data_write);
      end
      if (resp_valid) begin
        if (q.size() == 0) chk("unexpected_resp", 32'(resp_valid), 32'd0);
        else begin
          sb_t e;
          e = q.pop_front();
          chk("latency", 32'(cyc - e.t0), 32'(e.lat));
          chk("resp_err", 32'(resp_err), 32'(e.err));
          chk("read_cycles", 32'(rd_n), 32'(e.rd));
          chk("write_cycles", 32'(wr_n), 32'(e.wr));
          if (e.chk_rd) chk("resp_rdata", resp_rdata, e.rdata);
          rd_n = 0;
          wr_n = 0;
        end
      end
    end
  end
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rt, input logic [31:0] exp, input logic chk_rd,
                       input logic err, input int rd, input int wr, input int lat);
    int n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_op     = op;
    req_addr   = a;
    req_wdata  = wd;
    req_rt_old = rt;
    q.push_back('{exp, chk_rd, err, rd, wr, lat, cyc, a});
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_op     = '0;
    req_addr   = '0;
    req_wdata  = '0;
    req_rt_old = '0;
  endtask
  task automatic wait_done();
    int n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("resp_timeout", 32'(q.size()), 32'd0);
    @(negedge clk);
  endtask
  initial begin
    int n;
    pl_en = 1'b1;
    pl_idx = 11'h400;
    pl_val = 32'h8899AABB;
    @(posedge clk);
    #1;
    pl_idx = 11'h401;
    pl_val = 32'h0;
    @(posedge clk);
    #1;
    pl_en = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_bus_en", {30'd0, data_read, data_write}, 32'd0);
    chk("rst_addr", data_address, 32'd0);
    chk("rst_wdata", data_writedata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    issue(LB,  32'h1001, 0, 0, 32'hFFFFFFAA, 1, 0, 1, 0, 2); wait_done();
    issue(LBU, 32'h1001, 0, 0, 32'h000000AA, 1, 0, 1, 0, 2); wait_done();
    issue(LHU, 32'h1002, 0, 0, 32'h00008899, 1, 0, 1, 0, 2); wait_done();
    issue(LH,  32'h1002, 0, 0, 32'hFFFF8899, 1, 0, 1, 0, 2); wait_done();
    issue(LWL, 32'h1001, 0, 32'h11223344, 32'hAABB3344, 1, 0, 1, 0, 2); wait_done();
    issue(LWR, 32'h1001, 0, 32'h11223344, 32'h118899AA, 1, 0, 1, 0, 2); wait_done();
    issue(SB,  32'h1003, 32'h12345677, 0, 0, 0, 0, 1, 1, 3); wait_done();
    chk("mem_after_sb", mem[11'h400], 32'h7799AABB);
    issue(LW,  32'h1002, 0, 0, 32'h118899AA, 1, 1, 0, 0, 2); wait_done();
    issue(4'hF, 32'h1000, 0, 0, 32'h118899AA, 1, 1, 0, 0, 2); wait_done();
    issue(LW,  32'h1000, 0, 0, 32'h7799AABB, 1, 0, 1, 0, 2); wait_done();
    issue(LBU, 32'h1003, 0, 0, 32'h00000077, 1, 0, 1, 0, 2); wait_done();
    issue(SW,  32'h1004, 32'hDEADBEEF, 0, 0, 0, 0, 0, 1, 2);
    n = 0;
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_resp_seen", 32'(resp_valid), 32'd1);
    issue(LW,  32'h1004, 0, 0, 32'hDEADBEEF, 1, 0, 1, 0, 2); wait_done();
    issue(SH,  32'h1006, 32'h0000CAFE, 0, 0, 0, 0, 1, 1, 3); wait_done();
    chk("mem_after_sh", mem[11'h401], 32'hCAFEBEEF);
    issue(SH,  32'h1000, 32'h00005555, 0, 0, 0, 0, 1, 1, 3);
    @(negedge clk);
    @(negedge clk);
    chk("rmw_wr_active", 32'(data_write), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_write_drop", 32'(data_write), 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("abort_no_resp", 32'(resp_valid), 32'd0);
    chk("abort_mem", mem[11'h400], 32'h7799AABB);
    q.delete();
    rd_n = 0;
    wr_n = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_mem_late", mem[11'h400], 32'h7799AABB);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mips_cpu_lsu.md
Name: mips_cpu_lsu

Overview:
- Load/store unit on the CPU side of the data-memory bus; the initiator that drives the word-addressed data memory (combinational read, write on posedge clk).
- Turns core load/store requests (LB/LBU/LH/LHU/LW/LWL/LWR/SB/SH/SW) into word-aligned bus cycles.
- Sub-word stores use read-modify-write; loads use extract/sign-extend.
- Little-endian byte order: byte offset 0 = bits [7:0].

Parameters:
- CHECK_ALIGN, 1, 1 = misaligned LH/LHU/SH/LW/SW reports err and makes no bus access; 0 = address low bits ignored for those ops.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  core request strobe
- req_ready  out  1  unit idle, request accepted when req_valid && req_ready
- req_op  in  4  lsu_op_t operation
- req_addr  in  32  effective byte address
- req_wdata  in  32  store data (rt)
- req_rt_old  in  32  current rt value, used by LWL/LWR merge
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  load result; valid only with resp_valid and a load op
- resp_err  out  1  misaligned access; qualifies resp_valid
- data_address  out  32  word-aligned bus address, {addr[31:2],2'b00}
- data_read  out  1  bus read enable
- data_write  out  1  bus write enable
- data_writedata  out  32  bus write word
- data_readdata  in  32  bus read word, combinational from memory

Behaviour:
- Reset (async, rst_n=0): state=IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, data_read=0, data_write=0, data_address=0, data_writedata=0. Bus enables drop in the same instant as reset.
- States: IDLE, LOAD, WRITE, RMW_RD, RMW_WR, ERR.
- IDLE: req_ready=1. On accept, latch op, addr, wdata and rt_old.
  - Misaligned (CHECK_ALIGN=1) -> ERR.
  - Load op -> LOAD.
  - SW -> WRITE.
  - SB/SH -> RMW_RD.
- LOAD: data_read=1, data_address=latched aligned address.
  - At the edge, capture the extracted result into resp_rdata; pulse resp_valid the next cycle; go to IDLE.
- WRITE: data_write=1, data_writedata=latched wdata; pulse resp_valid the next cycle; go to IDLE.
- RMW_RD: data_read=1. At the edge, merge the byte/half of wdata into data_readdata at offset addr[1:0] and store in an internal word buffer; go to RMW_WR.
- RMW_WR: data_write=1, data_writedata=buffer; pulse resp_valid the next cycle; go to IDLE.
- ERR: no bus access; pulse resp_valid with resp_err=1 the next cycle; resp_rdata unchanged; go to IDLE.
- data_read and data_write are never high in the same cycle. Both are 0 in IDLE and ERR.
- Latency (accept edge to resp_valid-high cycle):
  - loads, SW and error: 2 cycles
  - SB/SH: 3 cycles
- Back-to-back: resp_valid is asserted while in IDLE, so a new request may be accepted in the same cycle.
- Requests are registered on accept; the core need not hold the request fields afterwards.
- Extraction (k = addr[1:0]):
  - LB/LBU: byte k, sign- or zero-extended.
  - LH/LHU: half k[1], sign- or zero-extended.
  - LW: whole word.
  - LWL: (mem << 8*(3-k)) | (rt_old & ((1<<8*(3-k))-1)).
  - LWR: (mem >> 8*k) | (rt_old & ~(32'hFFFFFFFF >> 8*k)).
  - LWL and LWR are never misaligned.
- Merge: SB replaces byte k. SH replaces half k[1]. Other bytes are preserved from the read word.
- Reset mid-RMW: an abort between RMW_RD and RMW_WR leaves memory unchanged. No response is issued for the aborted request.
- Undefined req_op on accept: treat as misaligned (ERR path, resp_err=1).

Decomposition:
- Package mips_cpu_lsu_pkg holds:
  - lsu_op_t enum, 4-bit: LB=0, LBU=1, LH=2, LHU=3, LW=4, LWL=5, LWR=6, SB=7, SH=8, SW=9
  - state enum
  - is_load / is_store helper functions
- Sub-module mips_cpu_lsu_align, purely combinational:
  - extract: op, k, mem word, rt_old -> load result
  - merge: op, k, mem word, wdata -> store word
  - misaligned flag
- mips_cpu_lsu is the FSM plus registers around the sub-module.

Test Plan:
- Memory word 0x1000 = 0x8899AABB; LB addr 0x1001 -> data_read=1 for one cycle at address 0x1000, resp_rdata=0xFFFFFFAA; LBU same address -> 0x000000AA; LHU 0x1002 -> 0x00008899.
- SB wdata=0x12345677 addr 0x1003 on word 0x8899AABB -> one read cycle then one write cycle at 0x1000 with 0x7799AABB, resp_valid 3 cycles after accept.
- LWL addr 0x1001, rt_old=0x11223344, mem 0x8899AABB -> 0xAABB3344; LWR addr 0x1001 -> 0x118899AA.
- LW addr 0x1002 with CHECK_ALIGN=1 -> no data_read/data_write, resp_valid with resp_err=1 2 cycles after accept.
- Back-to-back SW 0x1004 = 0xDEADBEEF then LW 0x1004, second request accepted in the resp_valid cycle of the first -> resp_rdata=0xDEADBEEF.
- rst_n low during RMW_WR cycle of an SH -> data_write drops immediately, word unchanged, state IDLE, req_ready=1, no resp_valid.
